halflife_decay_ctrl: RTL

//  Command-side driver for the half-life counter (clk/rst/up/down/load/in/out interface).

---
 rtl/halflife_decay_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/halflife_decay_ctrl.sv
// Command-side sequencer for a half-life counter: loads a start value, then halves it
// once per PERIOD ticks with single down strobes, verifying every step on the readback.
module halflife_decay_ctrl #(
    parameter int W      = 4,
    parameter int PERIOD = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_tick_en,
    input  logic [W-1:0] i_init_val,
    input  logic [W-1:0] i_cnt_q,
    output logic         o_cnt_load,
    output logic [W-1:0] o_cnt_din,
    output logic         o_cnt_up,
    output logic         o_cnt_down,
    output logic [7:0]   o_half_cnt,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_STEP, S_CHECK, S_FIN
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_val;
    logic [W-1:0]  r_target;
    logic [W-1:0]  r_expect;
    logic [PW-1:0] r_per;
    logic          r_load;
    logic [W-1:0]  r_din;
    logic          r_down;
    logic [7:0]    r_half;
    logic          r_done;
    logic          r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= S_IDLE;
            r_val    <= '0;
            r_target <= '0;
            r_expect <= '0;
            r_per    <= '0;
            r_load   <= 1'b0;
            r_din    <= '0;
            r_down   <= 1'b0;
            r_half   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Strobes are single-cycle: set only on the transition into their state.
            r_load <= 1'b0;
            r_din  <= '0;
            r_down <= 1'b0;
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= S_IDLE;
                r_per   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_half <= '0;
                            r_err  <= 1'b0;
                            if (i_init_val != '0) begin
                                r_val   <= i_init_val;
                                r_load  <= 1'b1;
                                r_din   <= i_init_val;
                                r_per   <= '0;
                                r_state <= S_LOAD;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_LOAD:   r_state <= S_SETTLE;
                    S_SETTLE: begin
                        if (i_cnt_q != r_val) begin
                            r_err   <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (i_tick_en) begin
                            if (r_per == PER_LAST) begin
                                r_per    <= '0;
                                r_target <= i_cnt_q >> 1;
                                if (i_cnt_q == '0) begin
                                    r_state <= S_FIN;
                                end else begin
                                    r_down  <= 1'b1;
                                    r_state <= S_STEP;
                                end
                            end else begin
                                r_per <= r_per + 1'b1;
                            end
                        end
                    end
                    S_STEP: begin
                        r_expect <= i_cnt_q - 1'b1;
                        r_state  <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (i_cnt_q != r_expect) begin
                            r_err   <= 1'b1;
                            r_state <= S_FIN;
                        end else if (i_cnt_q > r_target) begin
                            r_down  <= 1'b1;
                            r_state <= S_STEP;
                        end else begin
                            if (r_half != 8'hFF) r_half <= r_half + 8'd1;
                            r_state <= (r_target == '0) ? S_FIN : S_WAIT;
                        end
                    end
                    S_FIN: begin
                        r_done  <= ~r_err;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_cnt_load = r_load;
    assign o_cnt_din  = r_din;
    assign o_cnt_up   = 1'b0;
    assign o_cnt_down = r_down;
    assign o_half_cnt = r_half;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule
